led_digits_scan_ctrl: RTL
=========================

Name: led_digits_scan_ctrl

Overview:
- Memory-mapped scan scheduler for the 8-digit charlieplexed LED display.
- Selects which digit the display driver lights, holds it for a programmable dwell time, and inserts optional blanking gaps between digits to suppress ghosting.
- Skips digits disabled in a mask and counts completed frames.
- Slave on the openMSP430 peripheral bus; digit_sel/digit_vld feed the display driver's digit-select input.

Parameters:
- BASE_ADDR, 15'h0098, register block base address, aligned to DEC_WD.
- DEC_WD, 3, address decoder bit width (4 word registers).
- DWELL_RST, 16'h000F, reset value of DWELL.

Ports:
- mclk  in  1  main system clock
- puc_rst_n  in  1  main system reset, asynchronous, active-low
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral enable, active-high
- per_we  in  2  byte write enables; [0] low byte, [1] high byte
- per_dout  out  16  peripheral read data; 0 when not selected
- digit_sel  out  3  index of the digit to light
- digit_vld  out  1  1 = light digit_sel; 0 = display blank
- frame_tick  out  1  one-cycle pulse on each frame wrap

Behaviour:
- Clock and reset: one clock, mclk. Reset is asynchronous, active-low (puc_rst_n).
- Register decode:
  - reg_sel = per_en & address match on per_addr[13:DEC_WD-1].
  - Word offset = per_addr[1:0].
  - Write = per_we != 0, per byte lane. Read = per_we == 0; read data is combinational.
- Register map (byte offsets):
  - 0x0 CTRL: [0] EN; [7:4] BLANK (0-15); other bits read 0.
  - 0x2 DWELL: 16 bits, R/W.
  - 0x4 MASK: [7:0] R/W, [15:8] read 0.
  - 0x6 STAT: read-only, writes ignored. [2:0] current digit; [3] busy (FSM != IDLE); [15:8] frame_cnt.
- Reset values: CTRL=0, DWELL=DWELL_RST, MASK=8'hFF, frame_cnt=0, state IDLE, cnt=0, digit_sel=0, digit_vld=0, frame_tick=0, per_dout=0.
- FSM states: IDLE, DWELL, BLANK.
  - IDLE: digit_vld=0. If EN && MASK!=0: digit_sel <= lowest set MASK bit, cnt <= DWELL, go to DWELL. No frame_tick on this entry.
  - DWELL: digit_vld=1. cnt decrements each cycle; the digit is lit for exactly DWELL+1 cycles. When cnt==0:
    - compute nxt = first set MASK bit after digit_sel, searching circularly (digit_sel+1 .. 7, then 0 .. digit_sel);
    - digit_sel <= nxt;
    - if nxt <= digit_sel (wrap, including a single-bit mask): frame_tick=1 for one cycle and frame_cnt++ (8-bit, wraps FF->00);
    - if BLANK==0: reload cnt <= DWELL and stay in DWELL, with no gap cycle;
    - else: cnt <= BLANK-1, go to BLANK.
  - BLANK: digit_vld=0 for exactly BLANK cycles; digit_sel already shows the next digit. At cnt==0: cnt <= DWELL, go to DWELL.
- Latency: the write cycle registers EN=1; the FSM enters DWELL on the following edge; digit_vld is high from that edge.
- EN=0 or MASK=0 while in DWELL/BLANK: go to IDLE on the next edge, digit_vld=0. digit_sel holds its value. No frame_tick.
- MASK change mid-dwell: the current dwell completes; nxt is computed from the new MASK at the cnt==0 edge. If the new MASK is 0, the rule above applies.
- DWELL or BLANK write mid-operation: takes effect at the next counter load only.
- Write to CTRL with EN still 1: no restart.
- Simultaneous frame wrap and CPU read of STAT: the read returns the pre-increment frame_cnt.
- frame_cnt clears only on reset.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

Test Plan:
- Reset, then read all registers -> CTRL=0000, DWELL=000F, MASK=00FF, STAT=0000; digit_vld=0.
- DWELL=3, BLANK=0, MASK=FF, EN=1 -> digit_sel 0..7 each lit 4 cycles, no gaps. frame_tick pulses once per 32 cycles, on the 7->0 transition. STAT[15:8] = 01 after the first wrap.
- DWELL=1, BLANK=2, MASK=8'b1000_0100 -> sequence 2 (2 cycles lit), 2 cycles blank, 7 (2 lit), 2 blank, then 2. frame_tick pulses on the 7->2 transition.
- MASK=8'h10, DWELL=0, BLANK=0 -> digit_sel stays 4, digit_vld stays 1, frame_tick high every cycle. After 256 cycles frame_cnt wraps back to its start value.
- Mid-dwell, write MASK=0 -> next edge state IDLE, digit_vld=0, STAT[3]=0. Then write MASK=01 -> digit 0 lit on the following edge.
- Assert puc_rst_n=0 mid-BLANK, off a clock edge -> outputs go to reset values immediately. Byte write of 0xAB to MASK high lane only -> MASK unchanged.

Source files
------------

// File: rtl/led_digits_scan_ctrl.sv
// Scan scheduler for the 8-digit charlieplexed LED display: picks the lit digit,
// holds it for DWELL+1 cycles, optionally blanks between digits, and counts frames.
module led_digits_scan_ctrl #(
    parameter logic [14:0] BASE_ADDR = 15'h0098,
    parameter int          DEC_WD    = 3,
    parameter logic [15:0] DWELL_RST = 16'h000F
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic [2:0]  digit_sel,
    output logic        digit_vld,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  digit_sel_q, digit_sel_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        frame_tick_q, frame_tick_d;

    logic        ctrl_en_q, ctrl_en_d;
    logic [3:0]  blank_q, blank_d;
    logic [15:0] dwell_q, dwell_d;
    logic [7:0]  mask_q, mask_d;

    logic        reg_sel;
    logic [1:0]  reg_off;
    logic        wr_lo;
    logic        wr_hi;
    logic        rd;
    logic        run_ok;
    logic [2:0]  first_digit;
    logic [2:0]  next_digit;

    // Lowest enabled digit, used when a scan starts from IDLE.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Circular search starting after cur; descending distance so the nearest wins,
    // and distance 8 lands back on cur itself for a single-bit mask.
    function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] idx;
        r = cur;
        for (int i = 8; i >= 1; i--) begin
            idx = cur + 3'(i);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    assign reg_sel     = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_off     = per_addr[1:0];
    assign wr_lo       = reg_sel & per_we[0];
    assign wr_hi       = reg_sel & per_we[1];
    assign rd          = reg_sel & (per_we == 2'b00);
    assign run_ok      = ctrl_en_q & (mask_q != 8'h00);
    assign first_digit = lowest_set(mask_q);
    assign next_digit  = next_set(mask_q, digit_sel_q);

    always_comb begin
        ctrl_en_d = ctrl_en_q;
        blank_d   = blank_q;
        dwell_d   = dwell_q;
        mask_d    = mask_q;
        if (wr_lo && reg_off == 2'd0) begin
            ctrl_en_d = per_din[0];
            blank_d   = per_din[7:4];
        end
        if (wr_lo && reg_off == 2'd1) dwell_d[7:0]  = per_din[7:0];
        if (wr_hi && reg_off == 2'd1) dwell_d[15:8] = per_din[15:8];
        if (wr_lo && reg_off == 2'd2) mask_d        = per_din[7:0];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_sel_d  = digit_sel_q;
        frame_cnt_d  = frame_cnt_q;
        frame_tick_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_ok) begin
                    digit_sel_d = first_digit;
                    cnt_d       = dwell_q;
                    state_d     = DWELL;
                end
            end
            DWELL: begin
                if (!run_ok) begin
                    state_d = IDLE;
                end else if (cnt_q == 16'd0) begin
                    digit_sel_d = next_digit;
                    if (next_digit <= digit_sel_q) begin
                        frame_tick_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                    end
                    if (blank_q == 4'd0) begin
                        cnt_d = dwell_q;
                    end else begin
                        cnt_d   = {12'd0, blank_q} - 16'd1;
                        state_d = BLANK;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            BLANK: begin
                if (!run_ok) begin
                    state_d = IDLE;
                end else if (cnt_q == 16'd0) begin
                    cnt_d   = dwell_q;
                    state_d = DWELL;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            digit_sel_q  <= '0;
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
            ctrl_en_q    <= 1'b0;
            blank_q      <= '0;
            dwell_q      <= DWELL_RST;
            mask_q       <= 8'hFF;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_sel_q  <= digit_sel_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
            ctrl_en_q    <= ctrl_en_d;
            blank_q      <= blank_d;
            dwell_q      <= dwell_d;
            mask_q       <= mask_d;
        end
    end

    // Combinational read, so a STAT read on a wrap edge sees the old frame count.
    always_comb begin
        per_dout = '0;
        if (rd) begin
            case (reg_off)
                2'd0:    per_dout = {8'd0, blank_q, 3'd0, ctrl_en_q};
                2'd1:    per_dout = dwell_q;
                2'd2:    per_dout = {8'd0, mask_q};
                default: per_dout = {frame_cnt_q, 4'd0, (state_q != IDLE), digit_sel_q};
            endcase
        end
    end

    assign digit_sel  = digit_sel_q;
    assign digit_vld  = (state_q == DWELL);
    assign frame_tick = frame_tick_q;

endmodule
